mem_bridge: RTL
===============

# mem_bridge

Memory-side bridge sitting directly downstream of the LC-3b datapath's MAR/MDR. It takes the control unit's level-held `mem_read`/`mem_write` request, together with the datapath's `mem_address`, `mem_wdata` and `byte_enable`, and runs a fixed-wait-state access on an external single-port SRAM. It returns `mem_rdata` with a one-cycle `mem_resp` pulse, which lets the control FSM's memory-wait states advance.

## Interface
- `WAIT`, default 2: SRAM wait states per access; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  read request, held high by control until it sees `mem_resp`.
- `mem_write`  in  1  write request, held high by control until it sees `mem_resp`.
- `mem_address`  in  16  byte address (MAR output); bit 0 is ignored for the word select.
- `mem_wdata`  in  16  write data (MDR output).
- `mem_byte_enable`  in  2  byte lanes for writes; [1] = high byte, [0] = low byte.
- `mem_rdata`  out  16  registered read data; valid in the `mem_resp` cycle and held until the next read completes.
- `mem_resp`  out  1  one-cycle completion pulse.
- `protocol_err`  out  1  sticky error flag; set when `mem_read` and `mem_write` are both high in IDLE.
- `access_count`  out  16  count of completed accesses; wraps.
- `sram_ce`  out  1  SRAM chip enable.
- `sram_we`  out  1  SRAM write enable.
- `sram_be`  out  2  SRAM byte enables.
- `sram_addr`  out  15  SRAM word address, equal to `mem_address[15:1]`.
- `sram_wdata`  out  16  SRAM write data.
- `sram_rdata`  in  16  SRAM read data; valid in the last wait cycle.

## Operation
- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE:**
  - When `mem_read | mem_write` is high, latch the address, wdata, byte enables and op into internal registers.
  - Load the wait counter with `WAIT-1` and go to ACCESS.
  - If both requests are high, perform a write and set `protocol_err`.
- **ACCESS:**
  - `sram_ce` = 1. `sram_addr`, `sram_wdata` and `sram_be` are driven from the latched registers and stay stable.
  - `sram_we` = latched op (write). `sram_be` = latched enables for writes, 2'b11 for reads.
  - The counter decrements each cycle.
  - When the counter reaches 0, capture `sram_rdata` into `mem_rdata` (reads only) and go to RESP.
- **RESP:**
  - `mem_resp` = 1 only if the original request line (read or write, per the latched op) is still high. Otherwise the cycle is silent.
  - `access_count` increments in this cycle whether or not `mem_resp` is asserted.
  - The FSM always returns to IDLE.
- **Request dropped mid-access:**
  - The access is never aborted; a started write always completes.
  - Only `mem_resp` is suppressed, per the RESP rule.
- **Write data hold:** a write leaves `mem_rdata` unchanged.
- **`byte_enable` 2'b00 on a write:** the SRAM cycle still runs with `sram_be` = 00 and still responds.
- **Outside ACCESS:** `sram_ce`, `sram_we` and `sram_be` are 0. `sram_addr` and `sram_wdata` hold their last latched values.

## Timing
- **Reset (asynchronous, while `reset_n` = 0):**
  - State = IDLE.
  - `mem_resp`, `sram_ce`, `sram_we` and `sram_be` = 0.
  - `mem_rdata`, `sram_addr`, `sram_wdata` and `access_count` = 0.
  - `protocol_err` = 0.
  - Reset during ACCESS deasserts `sram_ce`/`sram_we` immediately, without waiting for a clock edge.
- **Single access:**
  - Cycle 0: request high, FSM in IDLE.
  - Cycles 1..WAIT: ACCESS.
  - Cycle WAIT+1: RESP, `mem_resp` high.
  - Latency is WAIT+1 cycles from the request-visible cycle to the response cycle.
- **Back-to-back:** after RESP the FSM spends at least one IDLE cycle before the next request is sampled. A request held continuously therefore restarts at cycle WAIT+2.
- **Request line ignored during ACCESS/RESP:** request-line changes during ACCESS and RESP affect only the RESP-cycle `mem_resp` check.
- **Counter wrap:** `access_count` goes from 0xFFFF to 0x0000.

## Test plan
- **Reset values:** assert `reset_n` = 0 mid-ACCESS -> `sram_ce` = 0 with no clock edge; all outputs at their reset values; FSM in IDLE after release.
- **Read, WAIT=2:**
  - Stimulus: `mem_read` high at cycle 0, `mem_address` = 0x1234, `sram_rdata` = 0xBEEF during the ACCESS cycles.
  - Required: `sram_ce` high in cycles 1–2 with `sram_addr` = 0x091A, `sram_be` = 11, `sram_we` = 0.
  - Required: `mem_resp` high in cycle 3 only, `mem_rdata` = 0xBEEF, `access_count` = 1.
- **Byte write:**
  - Stimulus: `mem_write`, `mem_address` = 0x0101, `mem_wdata` = 0xAB00, `mem_byte_enable` = 10.
  - Required: `sram_we` = 1, `sram_be` = 10, `sram_wdata` = 0xAB00 in cycles 1–2; `mem_resp` in cycle 3; `mem_rdata` unchanged.
- **Dropped request:** `mem_write` deasserted in cycle 1 -> `sram_we` still high through cycle 2; no `mem_resp` in cycle 3; `access_count` still increments.
- **Simultaneous read and write:** both high in IDLE -> write cycle performed; `protocol_err` = 1 and stays 1 until reset.
- **Back-to-back reads and wrap:**
  - Stimulus: `mem_read` held high continuously, WAIT=1, preload count to 0xFFFF.
  - Required: `mem_resp` pulses at cycles 2, 5, 8; `access_count` reads 0x0000 after the first response.

Source files
------------

// File: rtl/mem_bridge_if.sv
// rtl/mem_bridge_if.sv - request/response and SRAM bus bundle for mem_bridge
interface mem_bridge_if;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic        protocol_err;
    logic [15:0] access_count;
    logic        sram_ce;
    logic        sram_we;
    logic [1:0]  sram_be;
    logic [14:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;

    // Bridge side: consumes requests and SRAM read data, drives everything else.
    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, sram_rdata,
        output mem_rdata, mem_resp, protocol_err, access_count,
        output sram_ce, sram_we, sram_be, sram_addr, sram_wdata
    );

    // Requester/SRAM side: the mirror image of the bridge.
    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, sram_rdata,
        input  mem_rdata, mem_resp, protocol_err, access_count,
        input  sram_ce, sram_we, sram_be, sram_addr, sram_wdata
    );
endinterface

// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - fixed-wait-state bridge from MAR/MDR requests to a single-port SRAM
module mem_bridge #(
    parameter int unsigned WAIT       = 2,       // SRAM wait states per access, 1..15
    parameter logic [15:0] COUNT_INIT = 16'h0000 // power-on value of access_count
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_bridge_if.slave  bus
);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic        op_write_q;
    logic [14:0] addr_q;
    logic [15:0] wdata_q;
    logic [1:0]  be_q;
    logic [15:0] rdata_q;
    logic [15:0] count_q;
    logic        perr_q;

    logic        start;
    logic        done;
    logic        ce;
    logic        we;
    logic [1:0]  be;
    logic        resp;

    // Byte-address LSB has no role in a 16-bit word select.
    logic unused_addr_lsb;
    assign unused_addr_lsb = bus.mem_address[0];

    // State register; async reset drops the SRAM strobes without a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode; strobes come straight from the state so they stay glitch-free per state.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        done    = 1'b0;
        ce      = 1'b0;
        we      = 1'b0;
        be      = 2'b00;
        resp    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    start   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ce = 1'b1;
                we = op_write_q;
                be = op_write_q ? be_q : 2'b11;
                if (cnt_q == 4'd0) begin
                    done    = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                // Requester may have abandoned the access; only answer a line still held.
                resp    = op_write_q ? bus.mem_write : bus.mem_read;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, wait counter, read capture, access counter and sticky error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= 4'd0;
            op_write_q <= 1'b0;
            addr_q     <= 15'd0;
            wdata_q    <= 16'd0;
            be_q       <= 2'b00;
            rdata_q    <= 16'd0;
            count_q    <= COUNT_INIT;
            perr_q     <= 1'b0;
        end else begin
            if (start) begin
                addr_q     <= bus.mem_address[15:1];
                wdata_q    <= bus.mem_wdata;
                be_q       <= bus.mem_byte_enable;
                op_write_q <= bus.mem_write;
                cnt_q      <= WAIT_LOAD;
                if (bus.mem_read && bus.mem_write) begin
                    perr_q <= 1'b1;
                end
            end else if (state_q == ACCESS && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (done) begin
                if (!op_write_q) begin
                    rdata_q <= bus.sram_rdata;
                end
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign bus.sram_ce      = ce;
    assign bus.sram_we      = we;
    assign bus.sram_be      = be;
    assign bus.sram_addr    = addr_q;
    assign bus.sram_wdata   = wdata_q;
    assign bus.mem_resp     = resp;
    assign bus.mem_rdata    = rdata_q;
    assign bus.access_count = count_q;
    assign bus.protocol_err = perr_q;
endmodule
